// File: rtl/boss_hp.sv
// Boss hit-point tracker: arms when the enemy wave is cleared, takes bullet
// hits with a post-hit invulnerability window, and latches defeat.
module boss_hp #(
    parameter int HP_INIT  = 400,
    parameter int DMG      = 10,
    parameter int BOSS_W   = 100,
    parameter int BOSS_H   = 60,
    parameter int COOLDOWN = 8
) (
    input  logic       clk22,
    input  logic       rst,
    input  logic       enma1,
    input  logic       enma2,
    input  logic       enma3,
    input  logic       enma4,
    input  logic       boss,
    input  logic [9:0] bossx,
    input  logic [9:0] bossy,
    input  logic [9:0] bullet_x,
    input  logic [9:0] bullet_y,
    input  logic       bullet_v,
    output logic [9:0] bosshp,
    output logic       hit_ack,
    output logic [1:0] phase,
    output logic       boss_dead
);

    typedef enum logic [1:0] {WAIT, FIGHT, COOL, DEAD} state_t;

    localparam logic [9:0] HP0 = 10'(HP_INIT);
    localparam logic [9:0] DM  = 10'(DMG);
    localparam logic [7:0] CD  = 8'(COOLDOWN - 1);

    state_t     state;
    logic [7:0] cnt;
    logic       any_enma;
    logic       hit;
    logic [10:0] x_end;
    logic [10:0] y_end;
    logic [9:0] hp_dec;
    logic [1:0] phase_nxt;

    assign any_enma = enma1 | enma2 | enma3 | enma4;

    // Widened sums keep a hitbox near the screen edge from wrapping
    assign x_end = {1'b0, bossx} + 11'(BOSS_W);
    assign y_end = {1'b0, bossy} + 11'(BOSS_H);

    assign hit = bullet_v
               && (bullet_x >= bossx) && ({1'b0, bullet_x} < x_end)
               && (bullet_y >= bossy) && ({1'b0, bullet_y} < y_end);

    assign hp_dec = (bosshp < DM) ? 10'd0 : bosshp - DM;

    always_comb begin
        phase_nxt = 2'd3;
        if (bosshp > 10'd300)
            phase_nxt = 2'd0;
        else if (bosshp > 10'd150)
            phase_nxt = 2'd1;
        else if (bosshp != 10'd0)
            phase_nxt = 2'd2;
    end

    always_ff @(posedge clk22) begin
        if (rst) begin
            state     <= WAIT;
            bosshp    <= HP0;
            cnt       <= 8'd0;
            hit_ack   <= 1'b0;
            boss_dead <= 1'b0;
            phase     <= 2'd0;
        end else begin
            hit_ack <= 1'b0;
            phase   <= phase_nxt;
            unique case (state)
                WAIT: begin
                    bosshp <= HP0;
                    if (!any_enma && boss)
                        state <= FIGHT;
                end
                FIGHT: begin
                    if (any_enma || !boss) begin
                        state  <= WAIT;
                        bosshp <= HP0;
                        cnt    <= 8'd0;
                    end else if (hit) begin
                        bosshp  <= hp_dec;
                        hit_ack <= 1'b1;
                        if (hp_dec == 10'd0) begin
                            state     <= DEAD;
                            boss_dead <= 1'b1;
                        end else begin
                            state <= COOL;
                            cnt   <= CD;
                        end
                    end
                end
                COOL: begin
                    if (any_enma) begin
                        state  <= WAIT;
                        bosshp <= HP0;
                        cnt    <= 8'd0;
                    end else if (cnt == 8'd0) begin
                        state <= FIGHT;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                DEAD: begin
                    bosshp    <= 10'd0;
                    boss_dead <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_boss_hp.sv
// Bench for boss_hp: directed scenarios plus random play, checked against
// a time-based reference model on two instances (HP 400 and HP 405).
module tb_boss_hp;

    localparam int BW = 100;
    localparam int BH = 60;
    localparam int CDN = 8;
    localparam int DM = 10;

    logic       clk22 = 1'b0;
    logic       rst = 1'b1;
    logic       enma1 = 0, enma2 = 0, enma3 = 0, enma4 = 0;
    logic       boss = 0;
    logic [9:0] bossx = 10'd400, bossy = 10'd75;
    logic [9:0] bullet_x = 0, bullet_y = 0;
    logic       bullet_v = 0;

    logic [9:0] hp_a, hp_b;
    logic       ack_a, ack_b, dead_a, dead_b;
    logic [1:0] ph_a, ph_b;

    int ncmp = 0;
    int nerr = 0;

    int hp_init [2] = '{400, 405};
    int m_hp    [2];
    int m_ready [2];
    int m_phase [2];
    bit m_armed [2];
    bit m_dead  [2];
    bit m_ack   [2];
    int t = 0;

    always #5 clk22 = ~clk22;

    boss_hp u_a (
        .clk22(clk22), .rst(rst),
        .enma1(enma1), .enma2(enma2), .enma3(enma3), .enma4(enma4),
        .boss(boss), .bossx(bossx), .bossy(bossy),
        .bullet_x(bullet_x), .bullet_y(bullet_y), .bullet_v(bullet_v),
        .bosshp(hp_a), .hit_ack(ack_a), .phase(ph_a), .boss_dead(dead_a)
    );

    boss_hp #(.HP_INIT(405)) u_b (
        .clk22(clk22), .rst(rst),
        .enma1(enma1), .enma2(enma2), .enma3(enma3), .enma4(enma4),
        .boss(boss), .bossx(bossx), .bossy(bossy),
        .bullet_x(bullet_x), .bullet_y(bullet_y), .bullet_v(bullet_v),
        .bosshp(hp_b), .hit_ack(ack_b), .phase(ph_b), .boss_dead(dead_b)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int phase_of(input int hp);
        if (hp > 300) return 0;
        if (hp > 150) return 1;
        if (hp > 0) return 2;
        return 3;
    endfunction

    // One clock edge: advance the model from the applied inputs, then compare
    task automatic step();
        int bx = int'(bossx);
        int by = int'(bossy);
        int x = int'(bullet_x);
        int y = int'(bullet_y);
        bit h = bullet_v && x >= bx && x < bx + BW && y >= by && y < by + BH;
        bit en = enma1 | enma2 | enma3 | enma4;
        for (int k = 0; k < 2; k++) begin
            m_phase[k] = rst ? 0 : phase_of(m_hp[k]);
            m_ack[k] = 0;
            if (rst) begin
                m_armed[k] = 0;
                m_dead[k] = 0;
                m_hp[k] = hp_init[k];
            end else if (m_dead[k]) begin
                m_hp[k] = 0;
            end else if (!m_armed[k]) begin
                m_hp[k] = hp_init[k];
                if (!en && boss) begin
                    m_armed[k] = 1;
                    m_ready[k] = t + 1;
                end
            end else if (en) begin
                m_armed[k] = 0;
                m_hp[k] = hp_init[k];
            end else if (t < m_ready[k]) begin
                m_hp[k] = m_hp[k];
            end else if (!boss) begin
                m_armed[k] = 0;
                m_hp[k] = hp_init[k];
            end else if (h) begin
                m_hp[k] = (m_hp[k] < DM) ? 0 : m_hp[k] - DM;
                m_ack[k] = 1;
                if (m_hp[k] == 0) m_dead[k] = 1;
                else m_ready[k] = t + CDN + 1;
            end
        end
        t++;
        @(posedge clk22);
        @(negedge clk22);
        chk("hp_a", int'(hp_a), m_hp[0]);
        chk("ack_a", int'(ack_a), int'(m_ack[0]));
        chk("ph_a", int'(ph_a), m_phase[0]);
        chk("dead_a", int'(dead_a), int'(m_dead[0]));
        chk("hp_b", int'(hp_b), m_hp[1]);
        chk("ack_b", int'(ack_b), int'(m_ack[1]));
        chk("ph_b", int'(ph_b), m_phase[1]);
        chk("dead_b", int'(dead_b), int'(m_dead[1]));
    endtask

    task automatic aim(input int x, input int y, input bit v);
        bullet_x = 10'(x);
        bullet_y = 10'(y);
        bullet_v = v;
    endtask

    task automatic idle(input int n);
        bullet_v = 0;
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        @(negedge clk22);
        rst = 1;
        step();
        chk("rst_hp", int'(hp_a), 400);
        chk("rst_ph", int'(ph_a), 0);
        rst = 0;
        boss = 1;
        step();
        chk("arm_hp", int'(hp_a), 400);

        aim(450, 100, 1);
        step();
        chk("hit1_hp", int'(hp_a), 390);
        chk("hit1_ack", int'(ack_a), 1);
        for (int i = 0; i < 8; i++) step();
        chk("cool_noack", int'(ack_a), 0);
        step();
        chk("hit2_ack", int'(ack_a), 1);
        chk("hit2_hp", int'(hp_a), 380);

        idle(10);
        aim(500, 100, 1); step();
        chk("edge_x_miss", int'(ack_a), 0);
        aim(450, 135, 1); step();
        chk("edge_y_miss", int'(ack_a), 0);
        aim(499, 134, 1); step();
        chk("edge_hit", int'(ack_a), 1);
        idle(10);
        bossx = 10'd1000;
        aim(1020, 100, 1); step();
        chk("nowrap_hit", int'(ack_a), 1);
        bossx = 10'd400;

        aim(450, 100, 1);
        step();
        enma2 = 1;
        step();
        chk("rearm_hp", int'(hp_a), 400);
        chk("rearm_ack", int'(ack_a), 0);
        enma2 = 0;
        idle(1);
        aim(450, 100, 1);
        step();
        step();
        step();
        rst = 1;
        step();
        rst = 0;
        chk("rstcool_hp", int'(hp_a), 400);
        chk("rstcool_ack", int'(ack_a), 0);
        bullet_v = 0;
        boss = 0;
        idle(12);

        for (int i = 0; i < 3000; i++) begin
            int ox;
            int oy;
            rst = ($urandom % 300) == 0;
            enma1 = ($urandom % 120) == 0;
            enma2 = ($urandom % 120) == 0;
            enma3 = ($urandom % 120) == 0;
            enma4 = ($urandom % 120) == 0;
            boss = ($urandom % 40) != 0;
            if (($urandom % 50) == 0) begin
                bossx = 10'($urandom);
                bossy = 10'($urandom);
            end
            ox = int'(bossx) + int'($urandom_range(0, 120)) - 10;
            oy = int'(bossy) + int'($urandom_range(0, 80)) - 10;
            if (ox < 0) ox = 0;
            if (ox > 1023) ox = 1023;
            if (oy < 0) oy = 0;
            if (oy > 1023) oy = 1023;
            aim(ox, oy, ($urandom % 4) != 0);
            step();
        end

        rst = 1;
        enma1 = 0; enma2 = 0; enma3 = 0; enma4 = 0;
        bossx = 10'd400;
        bossy = 10'd75;
        idle(1);
        rst = 0;
        boss = 1;
        aim(450, 100, 1);
        for (int i = 0; i < 420; i++) step();
        chk("dead_a_final", int'(dead_a), 1);
        chk("dead_b_final", int'(dead_b), 1);
        chk("ph_b_final", int'(ph_b), 3);
        enma3 = 1;
        boss = 0;
        step();
        enma3 = 0;
        boss = 1;
        for (int i = 0; i < 20; i++) step();
        chk("dead_hold_hp", int'(hp_b), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
